branch_target_lut: RTL
======================

// Module: branch_target_lut
// PURPOSE
//  Programmable PC-target / data-address lookup table for the 3BC processor.
//  Replaces the hard-coded 16x10 constant table with a parametrised register-backed table.
//  Read path stays combinational so fetch/branch timing is unchanged.
//  Contents are rewritable per entry or bulk-loaded through a valid/ready stream by a small FSM.
//  Sits beside the PC unit; Out feeds the branch-offset adder and the data-memory address mux.
// PARAMETERS
//  WIDTH        10              stored entry width (bits)
//  DEPTH        16              number of entries; must be >= 2
//  IDX_W        $clog2(DEPTH)   index width (derived)
//  OUT_W        10              output width; must be >= WIDTH
//  SIGNED       1               1: sign-extend entry to OUT_W; 0: zero-extend
//  ENTRY0_INIT  -402            reset value of entry 0 (WIDTH bits, two's complement)
//  FILL_INIT    1               reset value of entries 1..DEPTH-1
// PORTS
//  Clk        in   1      clock; all state updates on rising edge
//  Reset      in   1      asynchronous, active-high reset
//  Index      in   IDX_W  read index
//  Out        out  OUT_W  extended entry[Index], combinational
//  WrEn       in   1      single-entry write strobe
//  WrIndex    in   IDX_W  single-entry write index
//  WrData     in   WIDTH  single-entry write data
//  LoadStart  in   1      begin bulk load of entries 0..DEPTH-1
//  LoadData   in   WIDTH  bulk-load data word
//  LoadValid  in   1      LoadData valid
//  LoadReady  out  1      table accepts LoadData this cycle
//  Busy       out  1      bulk load in progress
//  LoadDone   out  1      one-cycle pulse after last entry written
// BEHAVIOUR
//  Reset (async assert, sync-safe release):
//   - entry0 = ENTRY0_INIT; all other entries = FILL_INIT
//   - FSM = IDLE; load counter = 0
//   - LoadReady = 0, Busy = 0, LoadDone = 0
//  Read:
//   - Out = ext(entry[Index]), ext per SIGNED, zero clock latency
//   - Index >= DEPTH (non-power-of-2 DEPTH) -> Out = 0
//   - a write becomes visible on Out the cycle after its edge; no write-through bypass
//  Single write (IDLE only):
//   - WrEn=1 at edge -> entry[WrIndex] <= WrData
//   - WrEn ignored while Busy
//   - WrIndex >= DEPTH -> write dropped
//  FSM states IDLE, LOAD, DONE:
//   - IDLE -> LOAD on LoadStart; load counter <= 0
//     - WrEn in same cycle still performs its write
//   - LOAD: LoadReady = 1, Busy = 1
//     - each edge with LoadValid & LoadReady: entry[cnt] <= LoadData; cnt++
//     - LoadValid low: hold, no write, no timeout
//     - accepting word DEPTH-1 -> DONE
//   - DONE: single cycle
//     - LoadDone = 1, Busy = 0, LoadReady = 0
//     - -> IDLE unconditionally
//   - LoadStart in LOAD or DONE is ignored
//   - no wrap: counter never passes DEPTH-1
//  Reset mid-load:
//   - all entries return to init values (partial load discarded)
//   - FSM -> IDLE, counter -> 0, no LoadDone pulse
//  Widths:
//   - counter is IDX_W+1 bits internally
//   - extension is pure bit replication/zero-fill; no saturation
// TESTING
//  1 Reset, sweep Index 0..15 -> Out[0]=10'h26E (-402), Out[1..15]=10'h001;
//    outputs LoadReady/Busy/LoadDone = 0
//  2 WrEn, WrIndex=5, WrData=10'h3FF, then Index=5 -> Out=10'h3FF next cycle;
//    entry 4 still 10'h001
//  3 LoadStart, then 16 words 10'h000..10'h00F with LoadValid dropped 2 cycles after word 7
//    -> LoadReady high throughout, LoadDone single pulse 1 cycle after word 15,
//       Out[i]=i for all i
//  4 During load at cnt=3, WrEn to index 9 with 10'h155
//    -> ignored; entry9 = loaded value 10'h009 after load
//  5 Reset asserted after 6 load words, asynchronously between edges
//    -> Busy drops immediately, entries back to init, no LoadDone
//  6 OUT_W=12, SIGNED=1 -> Out[0]=12'hE6E;
//    SIGNED=0 -> Out[0]=12'h26E;
//    DEPTH=12: Index=13 -> Out=0

Source files
------------

// File: rtl/branch_target_lut.sv
// Register-backed PC-target / data-address lookup table with a combinational read port,
// single-entry writes and a valid/ready bulk-load sequencer.
module branch_target_lut #(
  parameter int WIDTH       = 10,
  parameter int DEPTH       = 16,
  parameter int IDX_W       = $clog2(DEPTH),
  parameter int OUT_W       = 10,
  parameter int SIGNED      = 1,
  parameter int ENTRY0_INIT = -402,
  parameter int FILL_INIT   = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [IDX_W-1:0] Index,
  output logic [OUT_W-1:0] Out,
  input  logic             WrEn,
  input  logic [IDX_W-1:0] WrIndex,
  input  logic [WIDTH-1:0] WrData,
  input  logic             LoadStart,
  input  logic [WIDTH-1:0] LoadData,
  input  logic             LoadValid,
  output logic             LoadReady,
  output logic             Busy,
  output logic             LoadDone
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  localparam logic [IDX_W:0]   DEPTH_X = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W:0]   LAST    = (IDX_W + 1)'(DEPTH - 1);
  localparam logic [WIDTH-1:0] E0_INIT = WIDTH'(ENTRY0_INIT);
  localparam logic [WIDTH-1:0] F_INIT  = WIDTH'(FILL_INIT);

  state_t           state;
  logic [IDX_W:0]   cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_entry;
  logic             idx_ok;
  logic             wr_ok;

  // Indices beyond DEPTH only exist for non-power-of-2 depths; they read as zero.
  assign idx_ok = ({1'b0, Index} < DEPTH_X);
  assign wr_ok  = ({1'b0, WrIndex} < DEPTH_X);

  always_comb begin
    rd_entry = '0;
    if (idx_ok) rd_entry = mem[Index];
  end

  always_comb begin
    Out = '0;
    if (SIGNED != 0) Out = OUT_W'($signed(rd_entry));
    else             Out = OUT_W'(rd_entry);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= (i == 0) ? E0_INIT : F_INIT;
      end
      state     <= IDLE;
      cnt       <= '0;
      LoadReady <= 1'b0;
      Busy      <= 1'b0;
      LoadDone  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          LoadDone <= 1'b0;
          if (WrEn && wr_ok) mem[WrIndex] <= WrData;
          if (LoadStart) begin
            state     <= LOAD;
            cnt       <= '0;
            LoadReady <= 1'b1;
            Busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (LoadValid && LoadReady) begin
            mem[cnt[IDX_W-1:0]] <= LoadData;
            // The counter parks at zero on the final word instead of stepping to DEPTH.
            if (cnt == LAST) begin
              cnt       <= '0;
              state     <= DONE;
              LoadReady <= 1'b0;
              Busy      <= 1'b0;
              LoadDone  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          LoadDone <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          LoadReady <= 1'b0;
          Busy      <= 1'b0;
          LoadDone  <= 1'b0;
        end
      endcase
    end
  end

endmodule
